// File: rtl/instr_encoder_loader_pkg.sv
// Shared instruction word definitions used by the encoder/loader and the decode stage.
package instr_encoder_loader_pkg;

  localparam int OP_HI   = 15;
  localparam int R1_HI   = 11;
  localparam int R2_HI   = 7;
  localparam int LMC_BIT = 3;
  localparam int CC_HI   = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  // Pack decoded fields into one instruction word; immediate form replaces the low byte.
  function automatic logic [15:0] pack_word(
    input logic [3:0] op,
    input logic [3:0] r1,
    input logic [3:0] r2,
    input logic       lmc,
    input logic [2:0] cc,
    input logic       imm_mode,
    input logic [7:0] imm
  );
    logic [15:0] w;
    w = '0;
    w[OP_HI -: 4] = op;
    w[R1_HI -: 4] = r1;
    if (imm_mode) begin
      w[R2_HI:0] = imm;
    end else begin
      w[R2_HI -: 4] = r2;
      w[LMC_BIT]    = lmc;
      w[CC_HI:0]    = cc;
    end
    return w;
  endfunction

endpackage

// File: rtl/instr_encoder_loader_fifo.sv
// Small synchronous FIFO for packed instruction words; pointers carry an extra wrap bit.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  // Pointer update; contents are discarded on reset by clearing both pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; no reset needed since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/instr_encoder_loader.sv
// Packs instruction fields into 16-bit words, buffers them and writes them to instruction memory.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              Start,
  input  logic [ADDR_W-1:0] BaseAddr,
  input  logic              InValid,
  output logic              InReady,
  input  logic              InLast,
  input  logic [3:0]        Op,
  input  logic [3:0]        r1,
  input  logic [3:0]        r2,
  input  logic              LMC,
  input  logic [2:0]        CC,
  input  logic              ImmMode,
  input  logic [7:0]        Imm,
  input  logic              MemReady,
  output logic              MemWE,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [15:0]       MemData,
  output logic              Busy,
  output logic              Done,
  output logic              Wrapped
);

  state_t              state;
  state_t              state_nxt;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic [15:0]         word;
  logic [15:0]         head;
  logic [ADDR_W-1:0]   cnt;

  assign word = pack_word(Op, r1, r2, LMC, CC, ImmMode, Imm);

  instr_fifo #(
    .DEPTH (DEPTH),
    .W     (16)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESET_N),
    .push  (push),
    .pop   (pop),
    .din   (word),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state, handshake and FIFO control.
  always_comb begin
    state_nxt = state;
    InReady   = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (Start) state_nxt = S_RUN;
      end
      S_RUN: begin
        InReady = !full;
        push    = InValid && !full;
        pop     = !empty && MemReady;
        if (push && InLast) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        pop = !empty && MemReady;
        // Empty here means the final pop already launched its write, which lands this cycle.
        if (empty) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    Busy = (state != S_IDLE);
    Done = (state == S_DONE);
  end

  // Memory write port, address counter and sticky wrap flag.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt     <= '0;
      MemWE   <= 1'b0;
      MemAddr <= '0;
      MemData <= '0;
      Wrapped <= 1'b0;
    end else begin
      MemWE <= pop;
      if (state == S_IDLE && Start) begin
        cnt     <= BaseAddr;
        Wrapped <= 1'b0;
      end else if (pop) begin
        MemAddr <= cnt;
        MemData <= head;
        cnt     <= cnt + ADDR_W'(1);
        if (cnt == '1) Wrapped <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader with a queue-based write model.
module tb_instr_encoder_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  logic              CLK = 1'b0;
  logic              RESET_N = 1'b0;
  logic              Start = 1'b0;
  logic [ADDR_W-1:0] BaseAddr = '0;
  logic              InValid = 1'b0;
  logic              InReady;
  logic              InLast = 1'b0;
  logic [3:0]        Op = '0;
  logic [3:0]        r1 = '0;
  logic [3:0]        r2 = '0;
  logic              LMC = 1'b0;
  logic [2:0]        CC = '0;
  logic              ImmMode = 1'b0;
  logic [7:0]        Imm = '0;
  logic              MemReady = 1'b1;
  logic              MemWE;
  logic [ADDR_W-1:0] MemAddr;
  logic [15:0]       MemData;
  logic              Busy;
  logic              Done;
  logic              Wrapped;

  always #5 CLK = ~CLK;

  instr_encoder_loader #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .Start    (Start),
    .BaseAddr (BaseAddr),
    .InValid  (InValid),
    .InReady  (InReady),
    .InLast   (InLast),
    .Op       (Op),
    .r1       (r1),
    .r2       (r2),
    .LMC      (LMC),
    .CC       (CC),
    .ImmMode  (ImmMode),
    .Imm      (Imm),
    .MemReady (MemReady),
    .MemWE    (MemWE),
    .MemAddr  (MemAddr),
    .MemData  (MemData),
    .Busy     (Busy),
    .Done     (Done),
    .Wrapped  (Wrapped)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  int          total = 0;
  int          bad = 0;
  wr_t         expq[$];
  wr_t         e;
  logic [7:0]  next_addr = '0;
  bit          wrap_seen = 1'b0;
  int          nwrites = 0;
  int          nw0;
  logic [7:0]  last_addr = '0;
  logic [15:0] last_data = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Word value from field arithmetic: opcode nibble, r1 nibble, then either the immediate or r2/LMC/CC.
  function automatic logic [15:0] enc(input int op, input int f1, input int f2, input int lmc,
                                      input int cc, input int im, input int imm);
    if (im != 0) return 16'(op * 4096 + f1 * 256 + imm);
    return 16'(op * 4096 + f1 * 256 + f2 * 16 + lmc * 8 + cc);
  endfunction

  // Every observed write must be the next expected word at the next expected address.
  always @(negedge CLK) begin
    if (RESET_N) begin
      if (MemWE) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write", MemAddr, MemData);
        end else begin
          e = expq.pop_front();
          check("write_addr", MemAddr, e.addr);
          check("write_data", MemData, e.data);
          wrap_seen = wrap_seen | (e.addr == 8'hFF);
          check("wrapped_flag", Wrapped, wrap_seen);
          last_addr = MemAddr;
          last_data = MemData;
          nwrites++;
        end
      end
      if (Done) check("done_with_pending_words", expq.size(), 0);
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_InReady"}, InReady, 0);
    check({tag, "_MemWE"},   MemWE,   0);
    check({tag, "_MemAddr"}, MemAddr, 0);
    check({tag, "_MemData"}, MemData, 0);
    check({tag, "_Busy"},    Busy,    0);
    check({tag, "_Done"},    Done,    0);
    check({tag, "_Wrapped"}, Wrapped, 0);
  endtask

  task automatic start(input logic [7:0] base);
    @(negedge CLK);
    Start     = 1'b1;
    BaseAddr  = base;
    next_addr = base;
    wrap_seen = 1'b0;
    @(negedge CLK);
    Start = 1'b0;
  endtask

  // Present one field set and hold it until accepted; returns just after the accepting edge.
  task automatic send(input int op, input int f1, input int f2, input int lmc, input int cc,
                      input int im, input int imm, input bit last);
    int n;
    n = 0;
    @(negedge CLK);
    Op = 4'(op); r1 = 4'(f1); r2 = 4'(f2); LMC = 1'(lmc); CC = 3'(cc);
    ImmMode = 1'(im); Imm = 8'(imm); InLast = last; InValid = 1'b1;
    while (!InReady && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!InReady) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got InReady=0 expected InReady=1 within 100 cycles");
      InValid = 1'b0;
      return;
    end
    expq.push_back('{next_addr, enc(op, f1, f2, lmc, cc, im, imm)});
    next_addr = next_addr + 8'd1;
    @(posedge CLK);
  endtask

  task automatic release_in();
    InValid = 1'b0;
    InLast  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    @(negedge CLK);
    while (!Done && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check({tag, "_done_seen"}, Done, 1);
    @(negedge CLK);
    check({tag, "_done_one_cycle"}, Done, 0);
    check({tag, "_busy_low"}, Busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(negedge CLK);
    check_reset("reset");
    RESET_N = 1'b1;

    // Register form, single word, latency and Done timing
    start(8'h10);
    check("reg_busy_after_start", Busy, 1);
    check("reg_inready_after_start", InReady, 1);
    send(3, 2, 5, 1, 2, 0, 0, 1);
    @(negedge CLK); release_in();
    check("reg_no_write_same_cycle", MemWE, 0);
    @(negedge CLK);
    check("reg_write_strobe", MemWE, 1);
    check("reg_write_addr", MemAddr, 8'h10);
    check("reg_write_data", MemData, 16'h325A);
    @(negedge CLK);
    check("reg_done", Done, 1);
    check("reg_strobe_one_cycle", MemWE, 0);
    check("reg_busy_in_done", Busy, 1);
    @(negedge CLK);
    check("reg_done_dropped", Done, 0);
    check("reg_busy_dropped", Busy, 0);

    // Immediate form
    start(8'h30);
    send(4'hB, 1, 0, 0, 0, 1, 8'hF0, 1);
    @(negedge CLK); release_in();
    wait_done("imm");
    check("imm_data", last_data, 16'hB1F0);
    check("imm_addr", last_addr, 8'h30);

    // Back-pressure: FIFO fills, then drains in order once memory is ready
    MemReady = 1'b0;
    start(8'h50);
    nw0 = nwrites;
    for (int i = 0; i < 4; i++) send(i + 1, i, 15 - i, i & 1, i, 0, 0, 0);
    @(negedge CLK);
    Op = 4'd9; r1 = 4'd8; ImmMode = 1'b1; Imm = 8'h5A; InLast = 1'b1; InValid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("bp_inready_low_when_full", InReady, 0);
      @(negedge CLK);
    end
    check("bp_no_write_while_stalled", nwrites - nw0, 0);
    MemReady = 1'b1;
    send(9, 8, 0, 0, 0, 1, 8'h5A, 1);
    @(negedge CLK); release_in();
    wait_done("bp");
    check("bp_write_count", nwrites - nw0, 5);
    check("bp_last_addr", last_addr, 8'h54);
    check("bp_last_data", last_data, 16'h985A);

    // Address wrap
    start(8'hFE);
    send(1, 1, 1, 0, 1, 0, 0, 0);
    send(2, 2, 2, 1, 2, 0, 0, 0);
    send(3, 3, 0, 0, 0, 1, 8'h33, 1);
    @(negedge CLK); release_in();
    wait_done("wrap");
    check("wrap_sticky", Wrapped, 1);
    check("wrap_last_addr", last_addr, 8'h00);

    // Reset during DRAIN with two words still buffered
    MemReady = 1'b0;
    start(8'h40);
    check("wrap_cleared_by_start", Wrapped, 0);
    send(5, 6, 7, 0, 1, 0, 0, 0);
    send(6, 5, 4, 1, 3, 0, 0, 1);
    @(negedge CLK); release_in();
    check("rst_busy_in_drain", Busy, 1);
    #2 RESET_N = 1'b0;
    #1 check_reset("midrst");
    expq.delete();
    nw0 = nwrites;
    repeat (3) @(negedge CLK);
    RESET_N  = 1'b1;
    MemReady = 1'b1;
    repeat (5) @(negedge CLK);
    check("rst_no_stale_write", nwrites - nw0, 0);
    check("rst_idle_after_release", Busy, 0);
    start(8'h20);
    send(7, 7, 7, 1, 7, 0, 0, 1);
    @(negedge CLK); release_in();
    wait_done("post_rst");
    check("post_rst_addr", last_addr, 8'h20);
    check("post_rst_data", last_data, 16'h777F);
    check("post_rst_write_count", nwrites - nw0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Writer side of the instruction word format: accepts decoded instruction fields and packs them into 16-bit instruction words.
- Buffers packed words in a small FIFO and writes them sequentially into instruction memory, starting at a programmed base address.
- Used by the boot/test loader path to build programs that the fetch/decode side later reads back.
- Field layout is the same one the decode stage splits apart: Op[15:12], r1[11:8], r2[7:4], LMC[3], CC[2:0]. In immediate form, bits [7:0] carry an 8-bit immediate instead of r2/LMC/CC.

Parameters:
- ADDR_W, 8, instruction memory address width.
- DEPTH, 4, FIFO depth in words (power of two, ≥2).

Ports:
- CLK  input  1  system clock, rising edge.
- RESET_N  input  1  asynchronous active-low reset.
- Start  input  1  one-cycle pulse; begins a load session (honoured only in IDLE).
- BaseAddr  input  ADDR_W  first write address, sampled with Start.
- InValid  input  1  field set valid.
- InReady  output  1  encoder can accept a field set.
- InLast  input  1  marks the final instruction of the session.
- Op  input  4  opcode.
- r1  input  4  register field 1.
- r2  input  4  register field 2.
- LMC  input  1  LMC bit.
- CC  input  3  condition code.
- ImmMode  input  1  1: low byte = Imm; 0: low byte = {r2,LMC,CC}.
- Imm  input  8  immediate byte.
- MemReady  input  1  memory can take a write this cycle.
- MemWE  output  1  write strobe.
- MemAddr  output  ADDR_W  write address.
- MemData  output  16  write data.
- Busy  output  1  session in progress.
- Done  output  1  one-cycle pulse at session end.
- Wrapped  output  1  sticky: address wrapped during the current session.

Behaviour:
- Reset (asynchronous, RESET_N=0):
  - State=IDLE, FIFO empty, address counter=0.
  - InReady=0, MemWE=0, MemAddr=0, MemData=0, Busy=0, Done=0, Wrapped=0.
- Packing (combinational, at the input):
  - ImmMode=0: word = {Op, r1, r2, LMC, CC}.
  - ImmMode=1: word = {Op, r1, Imm}.
- States:
  - IDLE: Start → latch BaseAddr into the address counter, clear Wrapped, go to RUN. Start outside IDLE is ignored.
  - RUN: InReady = !full. A transfer occurs when InValid & InReady; the packed word is pushed into the FIFO. A transfer with InLast=1 → DRAIN. InValid is ignored unless InReady=1.
  - DRAIN: InReady=0. When the FIFO is empty and no write is in flight → DONE.
  - DONE: Done=1 for one cycle, then IDLE.
- Busy=1 in RUN, DRAIN and DONE.
- Memory side (active in RUN and DRAIN):
  - MemWE is registered: asserted in cycle t+1 when the FIFO is non-empty and MemReady=1 in cycle t.
  - Same edge drives MemData=FIFO head and MemAddr=counter, pops the FIFO, and increments the counter after the write.
  - MemWE is held high for exactly one cycle per word.
  - MemReady=0 stalls writes; the FIFO holds its contents.
- Latency: a field set accepted at edge t appears at MemWE at edge t+1 at the earliest (empty FIFO, MemReady=1).
- Throughput: one word per cycle sustained.
- Simultaneous push and pop on the same edge is legal, including when the FIFO is full, provided the pop is decided on that edge. InReady reflects the pre-edge full flag, so a full FIFO gives InReady=0 even while a pop is pending.
- Address wrap: counter at 2^ADDR_W−1 increments to 0 and sets Wrapped=1. Wrapped is held until the next Start or reset.
- Session with zero words: not supported. A session ends only via an InLast transfer.
- Reset mid-session: everything returns to reset values and FIFO contents are discarded. No partial MemWE may appear after RESET_N falls.

Decomposition:
- Shared package (also used by the decode stage):
  - Field position constants: OP_HI=15, R1_HI=11, R2_HI=7, LMC_BIT=3, CC_HI=2.
  - State encoding: IDLE, RUN, DRAIN, DONE.
- One sub-module: instr_fifo (DEPTH×16, push/pop/full/empty, pointer wrap with extra MSB).

Test Plan:
- Reg form: BaseAddr=8'h10; Op=3, r1=2, r2=5, LMC=1, CC=3'b010, InLast=1 → one MemWE with MemAddr=8'h10, MemData=16'h325A; Done one cycle later; Busy falls after Done.
- Immediate form: Op=4'hB, r1=1, ImmMode=1, Imm=8'hF0 → MemData=16'hB1F0.
- Back-pressure: MemReady=0 while 5 words are offered (DEPTH=4) → InReady=0 after 4 accepts, MemWE stays 0. Raise MemReady → 5 writes at consecutive addresses in order, then Done.
- Wrap: BaseAddr=8'hFE, 3 words → addresses FE, FF, 00; Wrapped=1 after the third write; next Start clears Wrapped.
- Reset mid-DRAIN with 2 words pending → all outputs return to reset values immediately; no further MemWE; a fresh session writes correctly from its own BaseAddr.
